// File: rtl/ac_cmd_conditioner.sv
// Debounces up/down switches and turns each press into one command, with auto-repeat while held.
// Latency: raw edge to cmd_valid is DEBOUNCE_CYCLES+2 clocks; a command that finds the slot full is dropped and counted.
module ac_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       sw_up,
    input  logic       sw_down,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic       cmd_dir,
    output logic       idle,
    output logic       conflict,
    output logic [3:0] drop_cnt
);
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]  RPT_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0]  RPT_PER   = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0]  RPT_ONE   = RW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD_UP = 2'd1,
        S_HOLD_DN = 2'd2,
        S_BOTH    = 2'd3
    } state_t;

    logic [1:0]          sw_raw;
    logic [1:0]          sync1;
    logic [1:0]          sync2;
    logic [1:0]          lvl;
    logic [1:0][DBW-1:0] db_cnt;
    logic                u;
    logic                d;

    state_t              state;
    state_t              state_nxt;
    logic [RW-1:0]       rpt;
    logic                gen;
    logic                gen_dir;

    assign sw_raw = {sw_down, sw_up};
    assign u      = lvl[0];
    assign d      = lvl[1];

    // Bit 0 is the up switch, bit 1 the down switch.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            lvl    <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        lvl[i]    <= ~lvl[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DBW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gen       = 1'b0;
        gen_dir   = 1'b0;
        case (state)
            S_IDLE: begin
                if (u && d) begin
                    state_nxt = S_BOTH;
                end else if (u) begin
                    state_nxt = S_HOLD_UP;
                    gen       = 1'b1;
                    gen_dir   = 1'b1;
                end else if (d) begin
                    state_nxt = S_HOLD_DN;
                    gen       = 1'b1;
                end
            end
            S_HOLD_UP: begin
                if (d) begin
                    state_nxt = S_BOTH;
                end else if (!u) begin
                    state_nxt = S_IDLE;
                end else if (rpt == RPT_ONE) begin
                    gen     = 1'b1;
                    gen_dir = 1'b1;
                end
            end
            S_HOLD_DN: begin
                if (u) begin
                    state_nxt = S_BOTH;
                end else if (!d) begin
                    state_nxt = S_IDLE;
                end else if (rpt == RPT_ONE) begin
                    gen = 1'b1;
                end
            end
            S_BOTH: begin
                if (!u && !d) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rpt       <= '0;
            cmd_valid <= 1'b0;
            cmd_dir   <= 1'b0;
            idle      <= 1'b1;
            conflict  <= 1'b0;
            drop_cnt  <= 4'd0;
        end else begin
            state    <= state_nxt;
            idle     <= (state_nxt == S_IDLE);
            conflict <= (state_nxt == S_BOTH);

            // Holds are only entered from IDLE, so preloading there arms the first repeat.
            if (state == S_IDLE) begin
                rpt <= RPT_DELAY;
            end else if (state == S_HOLD_UP || state == S_HOLD_DN) begin
                rpt <= (rpt == RPT_ONE) ? RPT_PER : rpt - RW'(1);
            end

            if (gen) begin
                if (!cmd_valid || cmd_ready) begin
                    cmd_valid <= 1'b1;
                    cmd_dir   <= gen_dir;
                end else if (drop_cnt != 4'hF) begin
                    drop_cnt <= drop_cnt + 4'd1;
                end
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ac_cmd_conditioner.sv
// Randomized scoreboard bench for ac_cmd_conditioner: a cycle model predicts commands,
// a negedge monitor pops and compares each delivered command plus the status outputs.
module tb_ac_cmd_conditioner;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic       clk_2     = 1'b0;
    logic       reset     = 1'b0;
    logic       sw_up     = 1'b0;
    logic       sw_down   = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic       cmd_dir;
    logic       idle;
    logic       conflict;
    logic [3:0] drop_cnt;

    int n_checks    = 0;
    int n_fail      = 0;
    int n_delivered = 0;
    bit started     = 1'b0;

    ac_cmd_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .sw_up    (sw_up),
        .sw_down  (sw_down),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_dir  (cmd_dir),
        .idle     (idle),
        .conflict (conflict),
        .drop_cnt (drop_cnt)
    );

    always #5 clk_2 = ~clk_2;

    // Reference model: state after each rising edge.
    typedef enum int {M_IDLE, M_UP, M_DN, M_BOTH} mstate_t;
    mstate_t  m_state   = M_IDLE;
    bit [1:0] raw_prev1 = 2'b00;
    bit [1:0] raw_prev2 = 2'b00;
    bit [1:0] m_lvl     = 2'b00;
    int       m_streak[2];
    int       m_cyc     = 0;
    int       m_entry   = 0;
    bit       m_pending = 1'b0;
    int       m_drops   = 0;
    bit       exp_q[$];

    task automatic model_reset();
        m_state     = M_IDLE;
        raw_prev1   = 2'b00;
        raw_prev2   = 2'b00;
        m_lvl       = 2'b00;
        m_streak[0] = 0;
        m_streak[1] = 0;
        m_cyc       = 0;
        m_pending   = 1'b0;
        m_drops     = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit      u, d, mine, other, g, gdir;
        int      age;
        mstate_t nx;
        u    = m_lvl[0];
        d    = m_lvl[1];
        g    = 1'b0;
        gdir = 1'b0;
        nx   = m_state;
        case (m_state)
            M_IDLE: begin
                if (u && d) nx = M_BOTH;
                else if (u || d) begin
                    nx      = u ? M_UP : M_DN;
                    g       = 1'b1;
                    gdir    = u;
                    m_entry = m_cyc;
                end
            end
            M_UP, M_DN: begin
                mine  = (m_state == M_UP) ? u : d;
                other = (m_state == M_UP) ? d : u;
                if (other) nx = M_BOTH;
                else if (!mine) nx = M_IDLE;
                else begin
                    age = m_cyc - m_entry;
                    if (age == RD || (age > RD && (age - RD) % RP == 0)) begin
                        g    = 1'b1;
                        gdir = (m_state == M_UP);
                    end
                end
            end
            default: if (!u && !d) nx = M_IDLE;
        endcase

        // Debounce acts on the raw value seen two edges ago (synchronizer depth).
        for (int i = 0; i < 2; i++) begin
            if (raw_prev2[i] != m_lvl[i]) begin
                m_streak[i]++;
                if (m_streak[i] == DB) begin
                    m_lvl[i]    = ~m_lvl[i];
                    m_streak[i] = 0;
                end
            end else begin
                m_streak[i] = 0;
            end
        end
        raw_prev2 = raw_prev1;
        raw_prev1 = {sw_down, sw_up};

        if (g) begin
            if (!m_pending || cmd_ready) begin
                exp_q.push_back(gdir);
                m_pending = 1'b1;
            end else if (m_drops < 15) begin
                m_drops++;
            end
        end else if (m_pending && cmd_ready) begin
            m_pending = 1'b0;
        end
        m_state = nx;
        m_cyc++;
    endtask

    initial begin
        m_streak[0] = 0;
        m_streak[1] = 0;
        forever begin
            @(posedge clk_2 or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_2);
            if (started) begin
                check("cmd_valid", cmd_valid, m_pending);
                check("idle", idle, m_state == M_IDLE);
                check("conflict", conflict, m_state == M_BOTH);
                check("drop_cnt", drop_cnt, m_drops);
                if (cmd_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL cmd_unexpected: got dir %0d expected none at %0t", cmd_dir, $time);
                    end else begin
                        check("cmd_dir", cmd_dir, exp_q[0]);
                        if (cmd_ready) begin
                            void'(exp_q.pop_front());
                            n_delivered++;
                        end
                    end
                end
            end
        end
    end

    // rdy_mode: 0 = held low, 1 = held high, 2 = random per cycle.
    task automatic seg(input bit up, input bit dn, input int rdy_mode, input int n);
        for (int i = 0; i < n; i++) begin
            sw_up     = up;
            sw_down   = dn;
            cmd_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
            @(posedge clk_2);
            #2;
        end
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_2);
            #2;
        end
        reset = 1'b0;
    endtask

    initial begin
        int up, dn, len, mode;
        @(posedge clk_2);
        #2;
        pulse_reset(3);
        started = 1'b1;

        // Single press, then idle.
        seg(0, 0, 1, 10);
        seg(1, 0, 1, 20);
        seg(0, 0, 1, 15);
        // Long down hold with repeats.
        seg(0, 1, 1, 40);
        seg(0, 0, 1, 15);
        // Short glitch must be filtered.
        seg(1, 0, 1, DB - 1);
        seg(0, 0, 1, 15);
        // Up then both, release up alone, release all.
        seg(1, 0, 1, 20);
        seg(1, 1, 1, 30);
        seg(0, 1, 1, 20);
        seg(0, 0, 1, 15);
        // Blocked consumer: drops saturate, slot drains once.
        seg(1, 0, 0, 100);
        seg(0, 0, 0, 10);
        seg(0, 0, 1, 10);
        // Reset while holding with a pending command.
        seg(1, 0, 0, 12);
        pulse_reset(2);
        seg(1, 0, 1, 15);
        seg(0, 0, 1, 15);

        for (int s = 0; s < 80; s++) begin
            up   = $urandom_range(0, 1);
            dn   = ($urandom_range(0, 2) == 0) ? 1 : 0;
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB) : $urandom_range(DB + 2, 40);
            mode = $urandom_range(0, 2);
            seg(up[0], dn[0], mode, len);
            if ($urandom_range(0, 15) == 0) pulse_reset($urandom_range(1, 2));
        end

        seg(0, 0, 1, 30);
        check("queue_drained", exp_q.size(), 0);
        check("delivered_any", n_delivered > 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ac_cmd_conditioner.md
# ac_cmd_conditioner

Input-conditioning stage for the air-conditioner setpoint controller. Takes the raw increase/decrease switches, synchronizes and debounces them, resolves simultaneous presses, generates one command per press plus auto-repeat while held, and presents commands on a valid/ready handshake. The handshake lets the controller, which advances only on its slow divided tick, consume them without loss or duplication. Also reports an `idle` level, which the controller uses to enter its temperature-equalize step.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a switch change (≥1).
- `REPEAT_DELAY`, default 8: cycles from initial command to first auto-repeat (≥1).
- `REPEAT_PERIOD`, default 4: cycles between subsequent auto-repeats (≥1).

Ports:
- `clk_2`, input, 1: system clock; all state on rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `sw_up`, input, 1: raw increase switch, asynchronous to `clk_2`.
- `sw_down`, input, 1: raw decrease switch, asynchronous to `clk_2`.
- `cmd_ready`, input, 1: consumer accepts the presented command this cycle.
- `cmd_valid`, output, 1: a command is pending.
- `cmd_dir`, output, 1: 1 = increase, 0 = decrease; meaningful only while `cmd_valid`.
- `idle`, output, 1: both debounced switches released and FSM in IDLE.
- `conflict`, output, 1: FSM in BOTH.
- `drop_cnt`, output, 4: saturating count of commands lost because the output slot was full.

## Operation

Reset values:
- `cmd_valid` = 0, `cmd_dir` = 0, `idle` = 1, `conflict` = 0, `drop_cnt` = 0.
- Synchronizers, debounced levels, counters = 0; FSM = IDLE.

Synchronize/debounce (independent, identical per switch):
- Two-flop synchronizer, then a debounce counter of width clog2(DEBOUNCE_CYCLES+1).
- Counter increments each cycle the synchronized value differs from the debounced level, and clears on any cycle they match.
- Debounced level toggles, and the counter clears, on the DEBOUNCE_CYCLES-th consecutive mismatch cycle.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.

FSM (on debounced levels `u`, `d`):
- IDLE: `u&d` → BOTH (no command). `u&!d` → HOLD_UP, generate up. `d&!u` → HOLD_DN, generate down.
- HOLD_UP: `d` → BOTH (regardless of `u`). `!u&!d` → IDLE. Otherwise stay.
- HOLD_DN: symmetric to HOLD_UP.
- BOTH: stay until `!u&!d`, then → IDLE. A single remaining switch issues nothing until full release.

Repeat timer:
- Loaded with REPEAT_DELAY on entry to HOLD_UP/HOLD_DN; decrements each cycle in HOLD.
- At value 1: generate a command in the held direction and reload with REPEAT_PERIOD.
- Leaving HOLD abandons the timer.

Output slot (one entry):
- Slot frees when `cmd_valid & cmd_ready`.
- A generated command loads (`cmd_valid`=1, `cmd_dir` set) if the slot is empty or freed in that same cycle.
- Otherwise the command is discarded and `drop_cnt` increments, saturating at 15.
- Pending commands are never cleared by FSM transitions, including entry to BOTH.
- `cmd_dir` is stable while `cmd_valid` is high and not accepted.

## Timing

- Raw switch change sampled at edge k, held: debounced level changes at edge k+1+DEBOUNCE_CYCLES. FSM state and `cmd_valid` update at edge k+2+DEBOUNCE_CYCLES, i.e. k+6 at defaults.
- First repeat command is generated REPEAT_DELAY cycles after the initial command, then one every REPEAT_PERIOD cycles while held.
- `idle` and `conflict` are registered and change on the same edge as the FSM state.
- Accept and new load in the same cycle: `cmd_valid` stays 1 with the new `cmd_dir`; no drop.
- `reset` asserted mid-hold or with a command pending: outputs go to reset values immediately (asynchronous). After release, a still-held switch is re-debounced and issues a fresh initial command.

## Test plan

1. Reset, then `sw_up`=1 from edge 10, `cmd_ready`=1 → `cmd_valid` pulses for 1 cycle at edge 16 with `cmd_dir`=1; `idle` falls at edge 16.
2. `sw_down` held 40 cycles, `cmd_ready`=1 → down commands at relative cycles 0, 8, 12, 16, …; none after release; `idle` returns 1 six cycles after release.
3. `sw_up` glitch of 3 cycles → no command; `idle` stays 1; `drop_cnt`=0.
4. `sw_up` then `sw_down` pressed 20 cycles later, both held → `conflict`=1; repeats stop. Releasing `sw_up` alone → no command. Release both → `idle`=1.
5. `sw_up` held 100 cycles with `cmd_ready`=0 → one command pending (`cmd_dir`=1); `drop_cnt` saturates at 15. Raise `cmd_ready` → slot drains exactly once.
6. Assert `reset` while in HOLD_UP with `cmd_valid`=1 → `cmd_valid`=0, `idle`=1 immediately. Release `reset` with `sw_up` still high → new command 6 cycles later.
